// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: core bus defines, FSM encodings and the
// state enum used by if_stage and if_stage_pc.
`ifndef IF_STAGE_DEFINES_SVH
`define IF_STAGE_DEFINES_SVH
`define MEM_ADDR_BUS 31:0
`define INST_BUS     31:0
`define INST_NOP     32'h00000013
`define RST_N_ACTIVE 1'b0
`define IF_BOOT      1'b0
`define IF_RUN       1'b1
`define PC_STEP      32'd4
`endif

package if_stage_pkg;

  // Fetch FSM: a short boot delay after reset, then continuous fetch
  typedef enum logic {
    IF_BOOT_S = `IF_BOOT,
    IF_RUN_S  = `IF_RUN
  } ifState_e;

  localparam logic [31:0] INST_NOP_C = `INST_NOP;

  // Word-align an address by clearing its byte offset
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc.sv
// Program counter for the fetch stage: holds pc_q, selects between redirect
// target and the +4 increment, and flags misaligned redirect targets.
import if_stage_pkg::*;

module if_stage_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jump_i,
  input  logic [31:0]          jump_addr_i,
  input  logic                 advance_i,
  output logic [`MEM_ADDR_BUS] pc_o,
  output logic                 misalign_o
);

  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;

  // Redirect beats advance; the misalign flag lives for one cycle only
  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (jump_i) begin
      pc_d       = alignWord(jump_addr_i);
      misalign_d = |jump_addr_i[1:0];
    end else if (advance_i) begin
      pc_d = pc_q + `PC_STEP;
    end
  end

  // PC and misalign registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RST_N_ACTIVE) begin
      pc_q       <= alignWord(RESET_PC);
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: boot delay FSM, IF/ID pipeline register with a
// valid/ready handshake toward decode, and redirect/hold handling.
// Optional fetch/bubble performance counters are enabled by IF_STAGE_PERF_EN.
import if_stage_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [`MEM_ADDR_BUS] rom_addr_o,
  input  logic [`INST_BUS]     rom_inst_i,
  input  logic                 jump_i,
  input  logic [31:0]          jump_addr_i,
  input  logic                 hold_i,
  input  logic                 id_ready_i,
  output logic                 id_valid_o,
  output logic [31:0]          id_inst_o,
  output logic [31:0]          id_pc_o,
  output logic                 misalign_o
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0]          perf_fetch_o,
  output logic [31:0]          perf_bubble_o
`endif
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  ifState_e    state_q;
  logic [3:0]  bootCnt_q;
  logic        idValid_q;
  logic [31:0] idInst_q;
  logic [31:0] idPc_q;
  logic [31:0] pc;
  logic        canLoad;
  logic        advance;

  assign canLoad = !idValid_q || id_ready_i;
  assign advance = (state_q == IF_RUN_S) && !jump_i && !hold_i && canLoad;

  if_stage_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .jump_i      (jump_i),
    .jump_addr_i (jump_addr_i),
    .advance_i   (advance),
    .pc_o        (pc),
    .misalign_o  (misalign_o)
  );

  assign rom_addr_o = alignWord(pc);

  // Boot/run FSM together with the IF/ID register it controls
  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RST_N_ACTIVE) begin
      state_q   <= IF_BOOT_S;
      bootCnt_q <= 4'd0;
      idValid_q <= 1'b0;
      idInst_q  <= INST_NOP_C;
      idPc_q    <= 32'h0;
    end else begin
      case (state_q)
        IF_BOOT_S: begin
          if (bootCnt_q == BOOT_LAST) begin
            state_q <= IF_RUN_S;
          end else begin
            bootCnt_q <= bootCnt_q + 4'd1;
          end
        end
        IF_RUN_S: begin
          if (jump_i) begin
            idValid_q <= 1'b0;
            idInst_q  <= INST_NOP_C;
          end else if (hold_i) begin
            if (idValid_q && id_ready_i) begin
              idValid_q <= 1'b0;
            end
          end else if (canLoad) begin
            idValid_q <= 1'b1;
            idInst_q  <= rom_inst_i;
            idPc_q    <= pc;
          end
        end
        default: state_q <= IF_BOOT_S;
      endcase
    end
  end

  assign id_valid_o = idValid_q;
  assign id_inst_o  = idInst_q;
  assign id_pc_o    = idPc_q;

`ifdef IF_STAGE_PERF_EN
  logic [31:0] perfFetch_q;
  logic [31:0] perfBubble_q;

  // Saturating counts of handshakes and of empty run cycles decode could take
  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RST_N_ACTIVE) begin
      perfFetch_q  <= 32'h0;
      perfBubble_q <= 32'h0;
    end else begin
      if (idValid_q && id_ready_i && (perfFetch_q != 32'hFFFF_FFFF)) begin
        perfFetch_q <= perfFetch_q + 32'd1;
      end
      if ((state_q == IF_RUN_S) && !idValid_q && id_ready_i &&
          (perfBubble_q != 32'hFFFF_FFFF)) begin
        perfBubble_q <= perfBubble_q + 32'd1;
      end
    end
  end

  assign perf_fetch_o  = perfFetch_q;
  assign perf_bubble_o = perfBubble_q;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage: owns the program counter, drives the combinational instruction ROM address, and captures the returned word into the IF/ID pipeline register.
- Presents the fetched instruction and its PC to decode through a valid/ready handshake.
- Accepts redirects (jump/branch/trap) and a global hold from the pipeline controller.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BOOT_CYCLES, 1, idle cycles after reset release before the first fetch (range 1-15).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low (asserted = 0).
- rom_addr_o  output  32 (`MEM_ADDR_BUS)  fetch address to the instruction ROM; equals pc_q.
- rom_inst_i  input  32 (`INST_BUS)  ROM data for rom_addr_o, valid in the same cycle (combinational ROM).
- jump_i  input  1  redirect request.
- jump_addr_i  input  32  redirect target.
- hold_i  input  1  controller stall; blocks new fetches.
- id_ready_i  input  1  decode can accept this cycle.
- id_valid_o  output  1  id_inst_o/id_pc_o hold a live instruction.
- id_inst_o  output  32  fetched instruction.
- id_pc_o  output  32  PC of id_inst_o.
- misalign_o  output  1  one-cycle pulse: last redirect target had addr[1:0] != 0.

Behaviour:
- Reset (rst=0, async):
  - pc_q=RESET_PC; state=BOOT; boot counter=0.
  - id_valid_o=0; id_inst_o=`INST_NOP (32'h00000013); id_pc_o=0; misalign_o=0.
- rom_addr_o = {pc_q[31:2],2'b00} at all times, including during BOOT.
- FSM states:
  - BOOT: no load. Counter increments each cycle; when it reaches BOOT_CYCLES-1, go to RUN. A jump_i in BOOT updates pc_q but the BOOT count continues.
  - RUN: normal fetch.
  - There is no other state.
- RUN, per-cycle priority: redirect > hold > advance.
  1. Redirect (jump_i=1):
     - pc_q <= {jump_addr_i[31:2],2'b00}.
     - id_valid_o <= 0 and id_inst_o <= NOP, regardless of id_ready_i; any un-consumed instruction is discarded.
     - misalign_o <= |jump_addr_i[1:0].
     - rom_inst_i this cycle is not captured.
  2. Hold (hold_i=1, jump_i=0):
     - pc_q is unchanged.
     - If id_valid_o && id_ready_i, id_valid_o <= 0 (consumed, no refill); otherwise the outputs are unchanged.
  3. Advance (can_load = !id_valid_o || id_ready_i):
     - id_inst_o <= rom_inst_i; id_pc_o <= pc_q; id_valid_o <= 1; pc_q <= pc_q + 4.
  4. Stall (id_valid_o && !id_ready_i): all registers unchanged. id_inst_o/id_pc_o must stay bit-stable while valid and not ready.
- Throughput and latency:
  - 1 instruction/cycle with id_ready_i tied high.
  - Address-to-output latency is 1 cycle.
  - The first valid output appears BOOT_CYCLES+1 cycles after reset release.
- misalign_o: cleared every cycle in which no misaligned redirect occurs.
- PC arithmetic: 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. pc_q[1:0] is always 0.
- Reset mid-stall or mid-redirect: the async reset wins immediately and no partial update survives.
- id_pc_o always equals the address whose data is in id_inst_o.

Optional Feature:
- Macro: IF_STAGE_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_o[31:0] and perf_bubble_o[31:0], both reset to 0 and saturating at all-ones.
  - perf_fetch_o increments on each handshake (id_valid_o && id_ready_i).
  - perf_bubble_o increments on each RUN cycle with id_valid_o=0 and id_ready_i=1.
- Undefined: the ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared defines header (existing core defines):
  - `MEM_ADDR_BUS, `INST_BUS, `INST_NOP.
  - New `RST_N_ACTIVE 1'b0.
  - New `IF_BOOT / `IF_RUN state encodings.
  - New `PC_STEP 32'd4.
- One sub-module: if_stage_pc (pc_q register, redirect mux, +4 incrementer, alignment and misalign flag).
- The IF/ID register, FSM and perf counters stay in if_stage.

Test Plan:
- Reset release, RESET_PC=0, BOOT_CYCLES=1, ready=1, ROM words W0..W3 -> id_valid_o rises on cycle 2; id_pc_o sequence 0,4,8,12; id_inst_o = W0..W3.
- id_ready_i=0 for 3 cycles while id_valid_o=1 at pc 8 -> id_inst_o and id_pc_o stay at 8/W2 and rom_addr_o stays 12; when ready rises, the next output is pc 12.
- jump_i=1 with jump_addr_i=32'h40 while ready=0 and valid=1 -> next cycle id_valid_o=0 and id_inst_o=NOP; following outputs have pc 0x40, 0x44; misalign_o=0.
- jump_addr_i=32'h0000_0106 -> rom_addr_o=32'h104 and misalign_o pulses high for exactly one cycle.
- hold_i=1 for 2 cycles with ready=1 -> the valid instruction is consumed and then id_valid_o=0; pc_q stays frozen; fetch resumes at the same pc after hold drops.
- RESET_PC=32'hFFFF_FFF8 -> outputs pc FFFF_FFF8, FFFF_FFFC, 0000_0000; reset pulse mid-stream -> outputs return to reset values immediately (async).
